// File: rtl/result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_buffer_pkg
// Description : Shared constants for the result_buffer slice. These are the
//               default FIFO geometry and the width and saturation value of
//               the optional drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
package result_buffer_pkg;

    localparam int RES_DATA_WIDTH_DEFAULT = 16;
    localparam int RES_DEPTH_DEFAULT      = 4;

    localparam int DROP_CNT_WIDTH = 16;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

endpackage : result_buffer_pkg
`default_nettype wire

// File: rtl/result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : result_buffer_if
// Description : Valid/ready result stream from the result buffer to its
//               consumer.
//   m_data  : head-of-FIFO result   (master -> slave)
//   m_valid : m_data is valid       (master -> slave)
//   m_ready : consumer accepts      (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface result_buffer_if
    import result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RES_DATA_WIDTH_DEFAULT
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface : result_buffer_if
`default_nettype wire

// File: rtl/result_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : result_buffer_mem
// Description : DEPTH x DATA_WIDTH register array. It has one synchronous
//               write port and one asynchronous read port. The storage is not
//               reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module result_buffer_mem
    import result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RES_DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = RES_DEPTH_DEFAULT,
    localparam int AW        = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [AW-1:0]         waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic [AW-1:0]         raddr,
    output logic      [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : result_buffer_mem
`default_nettype wire

// File: rtl/result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : result_buffer
// Description : Output FIFO for the polynomial-evaluation core. It captures
//               each y result on the core's out_valid strobe and presents the
//               results over a valid/ready stream. It reports the fill level
//               and a sticky overflow flag. A result that arrives while the
//               FIFO is full and not draining is dropped.
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-high
//   in_data  : core result y
//   in_valid : core out_valid strobe
//   m_if     : result stream (m_data / m_valid / m_ready)
//   level    : entries currently stored, 0..DEPTH
//   ovf      : sticky dropped-sample flag
//   clr_ovf  : clears ovf (and drop_cnt when enabled)
//   drop_cnt : saturating count of dropped samples. This port exists only
//              when RESULT_BUF_DROP_CNT_EN is defined.
// Config      : `define RESULT_BUF_DROP_CNT_EN adds the drop_cnt port and its
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RES_DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = RES_DEPTH_DEFAULT,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic [DATA_WIDTH-1:0]     in_data,
    input  wire logic                      in_valid,
    result_buffer_if.master                m_if,
    output logic      [CNT_WIDTH-1:0]      level,
    output logic                           ovf,
    input  wire logic                      clr_ovf
`ifdef RESULT_BUF_DROP_CNT_EN
    ,
    output logic      [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    localparam int PTR_W = CNT_WIDTH;
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rdata;

    // Each pointer has one extra wrap bit. The FIFO is full when the
    // pointers match in the address bits and differ in the wrap bit.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop  = ~empty & m_if.m_ready;
    // When the FIFO is full, a same-cycle pop frees the slot that the
    // incoming result is written into.
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    result_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    assign m_if.m_data  = rdata;
    assign m_if.m_valid = ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                level <= level - CNT_WIDTH'(1);
            end
        end
    end

    // If a drop and a clear happen in the same cycle, the drop takes
    // priority, so that event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef RESULT_BUF_DROP_CNT_EN
    // The clear restarts the count. A drop in the same cycle is counted as
    // the first drop after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            drop_cnt <= drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop && (drop_cnt != DROP_CNT_MAX)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end
`endif

endmodule : result_buffer
`default_nettype wire
